// File: rtl/fp_pkg.sv
// Shared single-precision field definitions, FSM state type and a NaN helper
// for the sequential vector subtractor.
package fp_pkg;
    localparam int          FP_W          = 32;
    localparam int          FP_SIGN_BIT   = 31;
    localparam int          FP_EXP_MSB    = 30;
    localparam int          FP_EXP_LSB    = 23;
    localparam logic [31:0] FP_CANON_NAN  = 32'h7FC0_0000;
    localparam logic [31:0] FP_ZERO       = 32'h0;

    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} vs_state_e;

    function automatic logic fp_is_nan(input logic [FP_W-1:0] v);
        return (&v[FP_EXP_MSB:FP_EXP_LSB]) && (|v[FP_EXP_LSB-1:0]);
    endfunction
endpackage

// File: rtl/floating_addition.sv
// Combinational IEEE-754 single-precision adder, round-to-nearest-even,
// with NaN/Inf handling and gradual underflow (subnormals in and out).
module FloatingAddition
    import fp_pkg::*;
(
    input  logic [FP_W-1:0] A,
    input  logic [FP_W-1:0] B,
    output logic [FP_W-1:0] result
);
    logic        a_nan, b_nan, a_inf, b_inf;
    logic [31:0] x, y;
    logic [7:0]  ex_eff, ey_eff, d;
    logic [26:0] mx, my, my_sh, n;
    logic [27:0] s;
    logic [9:0]  e, ef, efin;
    logic [4:0]  lz, sh;
    logic        rnd;
    logic [24:0] m_r;
    logic [22:0] frac;

    always_comb begin
        a_nan = fp_is_nan(A);
        b_nan = fp_is_nan(B);
        a_inf = (&A[30:23]) && (A[22:0] == '0);
        b_inf = (&B[30:23]) && (B[22:0] == '0);

        // x always carries the larger magnitude so the subtract never goes negative
        if (B[30:0] > A[30:0]) begin
            x = B; y = A;
        end else begin
            x = A; y = B;
        end
        ex_eff = (x[30:23] == '0) ? 8'd1 : x[30:23];
        ey_eff = (y[30:23] == '0) ? 8'd1 : y[30:23];
        mx     = {(x[30:23] != '0), x[22:0], 3'b000};
        my     = {(y[30:23] != '0), y[22:0], 3'b000};
        d      = ex_eff - ey_eff;

        if (d >= 8'd27) begin
            my_sh = {26'b0, |my};
        end else begin
            my_sh = my >> d;
            if ((my & ((27'd1 << d) - 27'd1)) != '0) my_sh[0] = 1'b1;
        end

        s = (x[31] == y[31]) ? ({1'b0, mx} + {1'b0, my_sh})
                             : ({1'b0, mx} - {1'b0, my_sh});
        e = {2'b00, ex_eff};

        lz = '0;
        for (int i = 0; i < 27; i++)
            if (s[i]) lz = 5'(26 - i);

        sh = '0;
        if (s[27]) begin
            n = {s[27:2], s[1] | s[0]};
            e = e + 10'd1;
        end else begin
            // never normalise below the minimum exponent: that leaves a subnormal
            sh = ({5'b0, lz} > (e - 10'd1)) ? 5'(e - 10'd1) : lz;
            n  = s[26:0] << sh;
            e  = e - {5'b0, sh};
        end

        ef   = n[26] ? e : 10'd0;
        rnd  = n[2] & (n[1] | n[0] | n[3]);
        m_r  = {1'b0, n[26:3]} + {24'b0, rnd};
        efin = ef + {9'b0, m_r[24] | ((ef == 10'd0) && m_r[23])};
        frac = m_r[24] ? m_r[23:1] : m_r[22:0];

        if (a_nan || b_nan || (a_inf && b_inf && (A[31] != B[31])))
            result = FP_CANON_NAN;
        else if (a_inf)
            result = A;
        else if (b_inf)
            result = B;
        else if (s == '0)
            result = {A[31] & B[31], 31'b0};
        else if (efin >= 10'd255)
            result = {x[31], 8'hFF, 23'b0};
        else
            result = {x[31], efin[7:0], frac};
    end
endmodule

// File: rtl/floating_subtraction.sv
// A - B via the shared adder with B's sign inverted; NaN payloads stay NaN.
module floating_subtraction
    import fp_pkg::*;
(
    input  logic [FP_W-1:0] A,
    input  logic [FP_W-1:0] B,
    output logic [FP_W-1:0] result
);
    FloatingAddition u_add (
        .A      (A),
        .B      ({~B[FP_SIGN_BIT], B[FP_SIGN_BIT-1:0]}),
        .result (result)
    );
endmodule

// File: rtl/vector_subtraction_seq.sv
// Sequential VLEN-element FP32 vector subtractor, one element per cycle.
// Optional flush-to-zero of subnormal results: define VECSUB_FTZ_EN.
module vector_subtraction_seq
    import fp_pkg::*;
#(
    parameter int VLEN = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [32*VLEN-1:0] A,
    input  logic [32*VLEN-1:0] B,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [32*VLEN-1:0] result
);
    localparam int IDXW = $clog2(VLEN) + 1;

    vs_state_e                 state_q, state_d;
    logic [IDXW-1:0]           idx_q, idx_d;
    logic [VLEN-1:0][FP_W-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic [FP_W-1:0]           a_el, b_el, diff, wr_el;

    always_comb begin
        a_el = '0;
        b_el = '0;
        for (int i = 0; i < VLEN; i++)
            if (idx_q == IDXW'(i)) begin
                a_el = a_q[i];
                b_el = b_q[i];
            end
    end

    floating_subtraction u_sub (
        .A      (a_el),
        .B      (b_el),
        .result (diff)
    );

`ifdef VECSUB_FTZ_EN
    assign wr_el = ((diff[FP_EXP_MSB:FP_EXP_LSB] == '0) && (diff[FP_EXP_LSB-1:0] != '0))
                   ? {diff[FP_SIGN_BIT], 31'b0} : diff;
`else
    assign wr_el = diff;
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        case (state_q)
            ST_IDLE: if (in_valid) begin
                a_d     = A;
                b_d     = B;
                idx_d   = '0;
                state_d = ST_BUSY;
            end
            ST_BUSY: begin
                for (int i = 0; i < VLEN; i++)
                    if (idx_q == IDXW'(i)) res_d[i] = wr_el;
                idx_d = idx_q + 1'b1;
                if (idx_q == IDXW'(VLEN - 1)) state_d = ST_DONE;
            end
            ST_DONE: if (out_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign result    = res_q;
endmodule

// File: tb/tb_vector_subtraction_seq.sv
// Directed bench for vector_subtraction_seq: VLEN=3 main instance plus VLEN=1 latency check.
module tb_vector_subtraction_seq;
    import fp_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [95:0] A, B, result;
    logic        v1_in_valid, v1_in_ready, v1_out_valid, v1_out_ready;
    logic [31:0] v1_A, v1_B, v1_result;
    int          n_cmp = 0;
    int          n_err = 0;
    int          lat;

    always #5 clk = ~clk;

    vector_subtraction_seq #(.VLEN(3)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready), .result(result)
    );

    vector_subtraction_seq #(.VLEN(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(v1_in_valid), .in_ready(v1_in_ready),
        .A(v1_A), .B(v1_B), .out_valid(v1_out_valid), .out_ready(v1_out_ready),
        .result(v1_result)
    );

    localparam logic [95:0] VA1 = {32'hC000_0000, 32'h3FC0_0000, 32'h4040_0000};
    localparam logic [95:0] VB1 = {32'h4000_0000, 32'h3FC0_0000, 32'h3F80_0000};
    localparam logic [95:0] VR1 = {32'hC080_0000, 32'h0000_0000, 32'h4000_0000};
    localparam logic [95:0] VA2 = {32'h3F80_0000, 32'h3F00_0000, 32'h40A0_0000};
    localparam logic [95:0] VB2 = {32'h4040_0000, 32'h3E80_0000, 32'h3F80_0000};
    localparam logic [95:0] VR2 = {32'hC000_0000, 32'h3E80_0000, 32'h4080_0000};
    localparam logic [95:0] VA3 = {32'h7F80_0000, 32'h3F80_0000, 32'h0080_0000};
    localparam logic [95:0] VB3 = {32'h7F80_0000, 32'h7FC0_0000, 32'h0040_0000};
    localparam logic [95:0] VA4 = {32'h8000_0000, 32'h7F7F_FFFF, 32'h3F80_0000};
    localparam logic [95:0] VB4 = {32'h0000_0000, 32'hFF7F_FFFF, 32'h3380_0000};
    localparam logic [95:0] VR4 = {32'h8000_0000, 32'h7F80_0000, 32'h3F7F_FFFF};
`ifdef VECSUB_FTZ_EN
    localparam logic [31:0] SUBN_EXP = 32'h0000_0000;
`else
    localparam logic [31:0] SUBN_EXP = 32'h0040_0000;
`endif

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Present a pair, step past the accept edge, then count edges until out_valid.
    task automatic send(input logic [95:0] a, input logic [95:0] b, input bit scramble,
                        output int l);
        A = a; B = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        l = 0;
        while (l < 20) begin
            if (scramble) begin
                A = {$urandom, $urandom, $urandom};
                B = ~A;
                in_valid = ~in_valid;
            end
            @(posedge clk); #1;
            l++;
            if (out_valid) break;
        end
        in_valid = 1'b0;
    endtask

    task automatic handoff(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_ov"}, {95'b0, out_valid}, 96'd0);
        chk({tag, "_ir"}, {95'b0, in_ready}, 96'd1);
    endtask

    initial begin
        rst_n = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0;
        v1_in_valid = 1'b0; v1_out_ready = 1'b0; v1_A = '0; v1_B = '0;
        #1 rst_n = 1'b0;
        #11;
        chk("rst_ir",  {95'b0, in_ready},  96'd1);
        chk("rst_ov",  {95'b0, out_valid}, 96'd0);
        chk("rst_res", result, 96'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        send(VA1, VB1, 1'b0, lat);
        chk("v1_lat", 96'(lat), 96'd3);
        chk("v1_res", result, VR1);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk("hold_ov",  {95'b0, out_valid}, 96'd1);
            chk("hold_ir",  {95'b0, in_ready},  96'd0);
            chk("hold_res", result, VR1);
        end
        handoff("v1_hs");
        chk("v1_keep", result, VR1);

        send(VA2, VB2, 1'b1, lat);
        chk("v2_lat", 96'(lat), 96'd3);
        chk("v2_res", result, VR2);
        handoff("v2_hs");

        // abort with one element already written
        A = VA2; B = VB2; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("mid_ov",  {95'b0, out_valid}, 96'd0);
        chk("mid_ir",  {95'b0, in_ready},  96'd1);
        chk("mid_res", result, 96'd0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        send(VA1, VB1, 1'b0, lat);
        chk("post_lat", 96'(lat), 96'd3);
        chk("post_res", result, VR1);
        handoff("post_hs");

        send(VA3, VB3, 1'b0, lat);
        chk("sp_subn",   {64'b0, result[31:0]}, {64'b0, SUBN_EXP});
        chk("sp_nan",    {95'b0, fp_is_nan(result[63:32])}, 96'd1);
        chk("sp_infinf", {95'b0, fp_is_nan(result[95:64])}, 96'd1);
        handoff("sp_hs");

        send(VA4, VB4, 1'b0, lat);
        chk("edge_res", result, VR4);
        handoff("edge_hs");

        v1_A = 32'h4040_0000; v1_B = 32'h3F80_0000; v1_in_valid = 1'b1;
        @(posedge clk); #1;
        v1_in_valid = 1'b0;
        lat = 0;
        while (lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (v1_out_valid) break;
        end
        chk("l1_lat", 96'(lat), 96'd1);
        chk("l1_res", {64'b0, v1_result}, {64'b0, 32'h4000_0000});
        v1_out_ready = 1'b1;
        @(posedge clk); #1;
        v1_out_ready = 1'b0;
        chk("l1_hs", {95'b0, v1_out_valid}, 96'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
